// File: rtl/p_hardisc.sv
// Shared types for the hardisc front end: aligner states, halfwords, fetch error codes.
// No logic; types and constants only.
// Not applicable (no handshake).
package p_hardisc;

  // One 16-bit parcel of the fetch stream
  typedef logic [15:0] halfword_t;

  // Aligner buffer occupancy
  typedef enum logic [1:0] {
    ALN_EMPTY = 2'd0,  // nothing buffered
    ALN_HALF  = 2'd1,  // lower half of an RVI waiting for its upper half
    ALN_RVC   = 2'd2   // a complete compressed instruction waiting to issue
  } aln_state;

  // Fetch error code carried alongside each word and instruction
  typedef logic [2:0] fetch_err_t;

  localparam fetch_err_t FETCH_ERR_NONE = 3'b000;

endpackage

// File: rtl/instr_aligner.sv
// Splits 32-bit fetch words into aligned RV32 instructions (RVI or zero-extended RVC).
// Zero latency: outputs are combinational from the buffer state and the current fetch word.
// Decode stall holds state and outputs; a buffered RVC blocks fetch for one accepted cycle.
module instr_aligner
  import p_hardisc::*;
(
  input  logic        s_clk_i,
  input  logic        s_resetn_i,
  input  logic        s_flush_i,
  input  logic        s_fetch_valid_i,
  input  logic [31:0] s_fetch_instr_i,
  input  logic        s_fetch_addr1_i,
  input  logic [2:0]  s_fetch_error_i,
  input  logic        s_fetch_pred_i,
  output logic        s_fetch_ready_o,
  input  logic        s_id_ready_i,
  output logic        s_aligned_valid_o,
  output logic [31:0] s_instr_o,
  output logic [2:0]  s_fetch_error_o,
  output logic        s_align_error_o,
  output logic        s_prediction_o
);

  // A parcel is compressed unless its two low bits are both set
  function automatic logic is_rvc(input halfword_t hw);
    return hw[1:0] != 2'b11;
  endfunction

  aln_state   state_q, state_d;
  halfword_t  buf_q, buf_d;
  fetch_err_t buf_err_q, buf_err_d;
  // In ALN_RVC this is the prediction of the buffered RVC; in ALN_HALF it marks
  // a prediction that was made from a half-instruction (misaligned prediction).
  logic       buf_pred_q, buf_pred_d;

  halfword_t  lo_hw;
  halfword_t  hi_hw;
  logic       load_upper;
  logic       drop_buffer;
  logic       buffer_only;

  assign lo_hw = s_fetch_instr_i[15:0];
  assign hi_hw = s_fetch_instr_i[31:16];

  // Decide what is presented this cycle and how the buffer evolves on acceptance
  always_comb begin
    s_aligned_valid_o = 1'b0;
    s_instr_o         = 32'h0;
    s_fetch_error_o   = FETCH_ERR_NONE;
    s_align_error_o   = 1'b0;
    s_prediction_o    = 1'b0;
    load_upper        = 1'b0;
    drop_buffer       = 1'b0;
    buffer_only       = 1'b0;

    if (!s_resetn_i || s_flush_i) begin
      // Restart: present nothing and forget everything buffered
      drop_buffer = 1'b1;
    end else if (state_q == ALN_RVC) begin
      // Buffered compressed instruction issues without touching the fetch word
      s_aligned_valid_o = 1'b1;
      s_instr_o         = {16'h0, buf_q};
      s_fetch_error_o   = buf_err_q;
      s_prediction_o    = buf_pred_q;
      drop_buffer       = s_id_ready_i;
    end else if (s_fetch_valid_i) begin
      if (state_q == ALN_HALF && !s_fetch_addr1_i) begin
        // Sequential word completes the buffered RVI with its lower halfword
        s_aligned_valid_o = 1'b1;
        s_instr_o         = {lo_hw, buf_q};
        s_fetch_error_o   = (buf_err_q != FETCH_ERR_NONE) ? buf_err_q : s_fetch_error_i;
        s_align_error_o   = buf_pred_q;
        load_upper        = s_id_ready_i;
      end else if (!s_fetch_addr1_i) begin
        // Word starts at the lower halfword with nothing pending
        s_aligned_valid_o = 1'b1;
        s_fetch_error_o   = s_fetch_error_i;
        if (is_rvc(lo_hw)) begin
          // Lower RVC does not end in the upper halfword, so no prediction applies
          s_instr_o  = {16'h0, lo_hw};
          load_upper = s_id_ready_i;
        end else begin
          s_instr_o      = s_fetch_instr_i;
          s_prediction_o = s_fetch_pred_i;
          drop_buffer    = s_id_ready_i;
        end
      end else begin
        // Jump target in the upper halfword: any half-RVI buffered is stale
        if (is_rvc(hi_hw)) begin
          s_aligned_valid_o = 1'b1;
          s_instr_o         = {16'h0, hi_hw};
          s_fetch_error_o   = s_fetch_error_i;
          s_prediction_o    = s_fetch_pred_i;
          drop_buffer       = s_id_ready_i;
        end else begin
          // Only the start of an RVI: absorb it even while decode is stalled
          buffer_only = 1'b1;
          load_upper  = 1'b1;
        end
      end
    end
  end

  // Fetch word is taken whenever decode advances, or when it only feeds the buffer
  always_comb begin
    s_fetch_ready_o = (s_resetn_i & s_id_ready_i & ~s_flush_i & (state_q != ALN_RVC))
                    | buffer_only;
  end

  // Next buffer contents: capture the upper halfword, clear, or hold
  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    buf_err_d  = buf_err_q;
    buf_pred_d = buf_pred_q;
    if (load_upper) begin
      state_d    = is_rvc(hi_hw) ? ALN_RVC : ALN_HALF;
      buf_d      = hi_hw;
      buf_err_d  = s_fetch_error_i;
      buf_pred_d = s_fetch_pred_i;
    end else if (drop_buffer) begin
      state_d    = ALN_EMPTY;
      buf_d      = '0;
      buf_err_d  = FETCH_ERR_NONE;
      buf_pred_d = 1'b0;
    end
  end

  // Aligner state and halfword buffer registers
  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) begin
      state_q    <= ALN_EMPTY;
      buf_q      <= '0;
      buf_err_q  <= FETCH_ERR_NONE;
      buf_pred_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      buf_err_q  <= buf_err_d;
      buf_pred_q <= buf_pred_d;
    end
  end

endmodule
